aish_zone_alarm_ctrl: RTL and testbench

- Consumes the 16-line zone outputs of the 1-to-16 sensor demultiplexer and the zone select/strobe that drives it.
- Qualifies each zone with a per-zone consecutive-hit filter and latches tripped zones.
- Runs the arm/exit/entry/alarm state machine that drives the siren and status outputs of the security monitoring system.

---
 rtl/aish_alarm_pkg.sv | 28 ++
 rtl/aish_zone_debounce.sv | 58 +++++
 rtl/aish_zone_alarm_ctrl.sv | 134 +++++++++++++
 tb/tb_aish_zone_alarm_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aish_alarm_pkg.sv
// Shared definitions for the zone alarm controller.
//   NZONES    : number of zone lines coming from the 1-to-16 sensor demux.
//   state_t   : FSM state codes; these values also appear on the state output.
//   zone_index: returns the index of the lowest set bit of a zone vector.
package aish_alarm_pkg;

    localparam int NZONES = 16;

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } state_t;

    // At most one trip bit is set per cycle, so "lowest set bit" is the
    // tripping zone.
    function automatic logic [3:0] zone_index(input logic [NZONES-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = NZONES - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/aish_zone_debounce.sv
// Per-zone consecutive-hit filter for the scanned sensor demux.
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   zone_y      : demux outputs; only bit scan_sel is meaningful
//   scan_sel    : zone currently routed by the demux
//   scan_valid  : strobe, zone_y[scan_sel] is sampled on this cycle
//   trip_vec    : registered one-cycle pulse, bit i set when zone i qualifies
//
// Handshake: scan_valid is a single-cycle strobe with no ready/back-pressure;
// the line zone_y[scan_sel] is sampled on exactly the cycles it is high.
import aish_alarm_pkg::*;

module aish_zone_debounce #(
    parameter int HITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NZONES-1:0] zone_y,
    input  logic [3:0]        scan_sel,
    input  logic              scan_valid,
    output logic [NZONES-1:0] trip_vec
);

    localparam int            HW      = $clog2(HITS + 1);
    localparam logic [HW-1:0] HITS_V  = HW'(HITS);
    localparam logic [HW-1:0] HITS_M1 = HW'(HITS - 1);
    localparam logic [HW-1:0] ONE     = HW'(1);

    logic [HW-1:0]     r_cnt [NZONES];
    logic [NZONES-1:0] r_trip_vec;
    logic              w_hit;
    logic [HW-1:0]     w_cur;

    assign w_hit = zone_y[scan_sel];
    assign w_cur = r_cnt[scan_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NZONES; i++) r_cnt[i] <= '0;
            r_trip_vec <= '0;
        end else begin
            r_trip_vec <= '0;
            if (scan_valid) begin
                if (w_hit) begin
                    // Saturate at HITS; the trip fires only on the step that
                    // reaches HITS, so a held zone cannot re-trip until cleared.
                    if (w_cur != HITS_V) r_cnt[scan_sel] <= w_cur + ONE;
                    if (w_cur == HITS_M1) r_trip_vec[scan_sel] <= 1'b1;
                end else begin
                    r_cnt[scan_sel] <= '0;
                end
            end
        end
    end

    assign trip_vec = r_trip_vec;

endmodule

// File: rtl/aish_zone_alarm_ctrl.sv
// Arm / exit / entry / alarm controller for the security monitor.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   zone_y        : demux outputs; only bit scan_sel is meaningful
//   scan_sel      : zone currently routed by the demux
//   scan_valid    : one-cycle sample strobe for zone_y[scan_sel]
//   arm, disarm   : request pulses (disarm code checked upstream)
//   ack           : clears latched zones, honoured only while DISARMED
//   siren         : high in ALARM
//   armed         : high in ARMED, ENTRY_DELAY, ALARM
//   delay_active  : high in EXIT_DELAY, ENTRY_DELAY
//   state         : current FSM state code
//   alarm_zones   : sticky latched tripped zones
//   first_zone    : zone that caused the current or last alarm
import aish_alarm_pkg::*;

module aish_zone_alarm_ctrl #(
    parameter int              HITS         = 3,
    parameter int              EXIT_CYCLES  = 1000,
    parameter int              ENTRY_CYCLES = 500,
    parameter logic [NZONES-1:0] ENTRY_MASK = 16'h0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NZONES-1:0] zone_y,
    input  logic [3:0]        scan_sel,
    input  logic              scan_valid,
    input  logic              arm,
    input  logic              disarm,
    input  logic              ack,
    output logic              siren,
    output logic              armed,
    output logic              delay_active,
    output logic [2:0]        state,
    output logic [NZONES-1:0] alarm_zones,
    output logic [3:0]        first_zone
);

    localparam int            MAXD       = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
    localparam int            CW         = $clog2(MAXD + 1);
    localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_CYCLES - 1);
    localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_CYCLES - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    state_t            r_state;
    logic [CW-1:0]     r_delay;
    logic [NZONES-1:0] r_zones;
    logic [3:0]        r_first;

    logic [NZONES-1:0] w_trip_vec;
    logic              w_trip;
    logic              w_trip_alarm;
    logic [3:0]        w_trip_idx;
    logic              w_delay_done;

    aish_zone_debounce #(
        .HITS (HITS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .zone_y     (zone_y),
        .scan_sel   (scan_sel),
        .scan_valid (scan_valid),
        .trip_vec   (w_trip_vec)
    );

    assign w_trip       = |w_trip_vec;
    // A trip on any zone outside the entry mask goes straight to ALARM.
    assign w_trip_alarm = |(w_trip_vec & ~ENTRY_MASK);
    assign w_trip_idx   = zone_index(w_trip_vec);
    assign w_delay_done = (r_delay == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DISARMED;
            r_delay <= '0;
            r_zones <= '0;
            r_first <= '0;
        end else if (disarm && (r_state != ST_DISARMED)) begin
            // disarm wins over arm and over any trip in the same cycle.
            r_state <= ST_DISARMED;
            r_delay <= '0;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    if (ack) begin
                        r_zones <= '0;
                        r_first <= '0;
                    end
                    if (arm && !disarm) begin
                        r_state <= ST_EXIT_DELAY;
                        r_delay <= EXIT_LOAD;
                    end
                end
                ST_EXIT_DELAY: begin
                    if (w_delay_done) r_state <= ST_ARMED;
                    else              r_delay <= r_delay - ONE;
                end
                ST_ARMED: begin
                    if (w_trip) begin
                        r_zones <= r_zones | w_trip_vec;
                        r_first <= w_trip_idx;
                        if (w_trip_alarm) begin
                            r_state <= ST_ALARM;
                        end else begin
                            r_state <= ST_ENTRY_DELAY;
                            r_delay <= ENTRY_LOAD;
                        end
                    end
                end
                ST_ENTRY_DELAY: begin
                    // first_zone keeps the entry zone even on escalation.
                    r_zones <= r_zones | w_trip_vec;
                    if (w_trip_alarm || w_delay_done) r_state <= ST_ALARM;
                    else                              r_delay <= r_delay - ONE;
                end
                ST_ALARM: begin
                    r_state <= ST_ALARM;
                end
                default: begin
                    r_state <= ST_DISARMED;
                end
            endcase
        end
    end

    assign state        = r_state;
    assign siren        = (r_state == ST_ALARM);
    assign armed        = (r_state == ST_ARMED) || (r_state == ST_ENTRY_DELAY) || (r_state == ST_ALARM);
    assign delay_active = (r_state == ST_EXIT_DELAY) || (r_state == ST_ENTRY_DELAY);
    assign alarm_zones  = r_zones;
    assign first_zone   = r_first;

endmodule

// File: tb/tb_aish_zone_alarm_ctrl.sv
// Testbench for aish_zone_alarm_ctrl (HITS=3, EXIT_CYCLES=8, ENTRY_CYCLES=5,
// ENTRY_MASK=16'h0001). A cycle-level behavioural model built from deadlines
// and per-zone hit counts predicts all outputs; a compare loop checks every
// cycle, and directed literal checks pin the model.
module tb_aish_zone_alarm_ctrl;

    localparam int          T_HITS  = 3;
    localparam int          T_EXIT  = 8;
    localparam int          T_ENTRY = 5;
    localparam logic [15:0] T_MASK  = 16'h0001;
    localparam int          EW      = 26;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] zone_y = '0;
    logic [3:0]  scan_sel = '0;
    logic        scan_valid = 1'b0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic        ack = 1'b0;
    logic        siren, armed, delay_active;
    logic [2:0]  state;
    logic [15:0] alarm_zones;
    logic [3:0]  first_zone;

    always #5 clk = ~clk;

    aish_zone_alarm_ctrl #(
        .HITS         (T_HITS),
        .EXIT_CYCLES  (T_EXIT),
        .ENTRY_CYCLES (T_ENTRY),
        .ENTRY_MASK   (T_MASK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .zone_y       (zone_y),
        .scan_sel     (scan_sel),
        .scan_valid   (scan_valid),
        .arm          (arm),
        .disarm       (disarm),
        .ack          (ack),
        .siren        (siren),
        .armed        (armed),
        .delay_active (delay_active),
        .state        (state),
        .alarm_zones  (alarm_zones),
        .first_zone   (first_zone)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode: 0 off, 1 leaving (exit window), 2 armed, 3 entering, 4 alarm.
    int          m_mode;
    longint      m_edge;
    longint      m_deadline;
    int          m_hits [16];
    int          m_trip;     // zone whose qualification is visible this cycle
    int          m_t;
    logic [15:0] m_zones;
    logic [3:0]  m_first;

    task model_reset();
        m_mode = 0;
        m_trip = -1;
        m_zones = '0;
        m_first = '0;
        for (int i = 0; i < 16; i++) m_hits[i] = 0;
    endtask

    task model_step();
        logic [EW-1:0] e;
        m_edge++;
        if (rst) begin
            model_reset();
        end else begin
            m_t = m_trip;
            m_trip = -1;
            if (disarm && m_mode != 0) begin
                m_mode = 0;
            end else begin
                case (m_mode)
                    0: begin
                        if (ack) begin
                            m_zones = '0;
                            m_first = '0;
                        end
                        if (arm && !disarm) begin
                            m_mode = 1;
                            m_deadline = m_edge + T_EXIT;
                        end
                    end
                    1: if (m_edge == m_deadline) m_mode = 2;
                    2: if (m_t >= 0) begin
                        m_zones[m_t] = 1'b1;
                        m_first = 4'(m_t);
                        if (T_MASK[m_t]) begin
                            m_mode = 3;
                            m_deadline = m_edge + T_ENTRY;
                        end else begin
                            m_mode = 4;
                        end
                    end
                    3: begin
                        if (m_t >= 0) m_zones[m_t] = 1'b1;
                        if (m_t >= 0 && !T_MASK[m_t]) m_mode = 4;
                        else if (m_edge == m_deadline) m_mode = 4;
                    end
                    default: ;
                endcase
            end
            if (scan_valid) begin
                if (zone_y[scan_sel]) begin
                    if (m_hits[scan_sel] < T_HITS) begin
                        m_hits[scan_sel]++;
                        if (m_hits[scan_sel] == T_HITS) m_trip = int'(scan_sel);
                    end
                end else begin
                    m_hits[scan_sel] = 0;
                end
            end
        end
        e = {m_mode == 4, m_mode >= 2, (m_mode == 1) || (m_mode == 3), 3'(m_mode), m_zones, m_first};
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic sv, input logic [3:0] sel, input logic zb,
                       input logic a, input logic d, input logic k, input logic r);
        @(negedge clk);
        #1;
        zone_y     = 16'($urandom);
        zone_y[sel] = zb;
        scan_sel   = sel;
        scan_valid = sv;
        arm        = a;
        disarm     = d;
        ack        = k;
        rst        = r;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        arm        = 1'b0;
        disarm     = 1'b0;
        ack        = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input logic [3:0] sel, input logic zb);
        cyc(1'b1, sel, zb, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_arm();    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_disarm(); cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic do_ack();    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask

    // ---------------- main ----------------
    initial begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        logic [3:0]    rs;
        m_edge = 0;
        m_deadline = 0;
        model_reset();

        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    act_v = {siren, armed, delay_active, state, alarm_zones, first_zone};
                    n_cmp++;
                    if (act_v !== exp_v) begin
                        n_bad++;
                        $display("FAIL cycle_compare: got %h expected %h at %0t", act_v, exp_v, $time);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_state", state, 0);
        chk("reset_siren", siren, 0);
        chk("reset_zones", alarm_zones, 0);
        chk("reset_first", first_zone, 0);
        chk("reset_armed", {armed, delay_active}, 0);

        // arm together with disarm stays disarmed
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("arm_disarm_prio", state, 0);

        // exit delay: 8 cycles in state 1; zone 3 trips meanwhile
        do_arm();
        chk("exit_enter", state, 1);
        chk("exit_flags", {armed, delay_active}, 2'b01);
        for (int i = 0; i < 7; i++) begin
            if (i < 3) strobe(4'd3, 1'b1);
            else       idle(1);
            chk("exit_hold", state, 1);
        end
        idle(1);
        chk("exit_to_armed", state, 2);
        chk("exit_trip_ignored", alarm_zones, 0);

        // filter: H H L H H must not trip zone 5
        strobe(4'd5, 1'b1);
        strobe(4'd5, 1'b1);
        strobe(4'd5, 1'b0);
        strobe(4'd5, 1'b1);
        strobe(4'd5, 1'b1);
        idle(2);
        chk("filter_no_trip", state, 2);
        strobe(4'd5, 1'b1);
        idle(1);
        chk("z5_alarm_state", state, 4);
        chk("z5_siren", siren, 1);
        chk("z5_zones", alarm_zones, 16'h0020);
        chk("z5_first", first_zone, 5);

        // ack ignored in ALARM; disarm then ack clears
        do_ack();
        chk("ack_in_alarm", alarm_zones, 16'h0020);
        do_disarm();
        chk("disarm_state", state, 0);
        chk("disarm_siren", siren, 0);
        do_ack();
        chk("ack_clear_zones", alarm_zones, 0);
        chk("ack_clear_first", first_zone, 0);

        // entry path, disarmed during entry delay
        do_arm();
        idle(8);
        chk("entry_armed", state, 2);
        strobe(4'd0, 1'b1);
        strobe(4'd0, 1'b1);
        strobe(4'd0, 1'b1);
        idle(1);
        chk("entry_state", state, 3);
        idle(1);
        chk("entry_no_siren", siren, 0);
        idle(1);
        do_disarm();
        chk("entry_disarm", state, 0);
        chk("entry_siren_off", siren, 0);
        strobe(4'd0, 1'b0);
        do_ack();

        // entry path expiring into alarm
        do_arm();
        idle(8);
        strobe(4'd0, 1'b1);
        strobe(4'd0, 1'b1);
        strobe(4'd0, 1'b1);
        idle(1);
        chk("entry2_state", state, 3);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("entry2_hold", state, 3);
        end
        idle(1);
        chk("entry2_alarm", state, 4);
        chk("entry2_first", first_zone, 0);
        chk("entry2_zones", alarm_zones, 16'h0001);
        do_disarm();
        do_ack();
        strobe(4'd0, 1'b0);

        // escalation: non-entry zone 9 during entry delay
        do_arm();
        idle(8);
        strobe(4'd9, 1'b1);
        strobe(4'd9, 1'b1);
        strobe(4'd0, 1'b1);
        strobe(4'd0, 1'b1);
        strobe(4'd0, 1'b1);
        idle(1);
        chk("esc_entry", state, 3);
        strobe(4'd9, 1'b1);
        idle(1);
        chk("esc_alarm", state, 4);
        chk("esc_zones", alarm_zones, 16'h0201);
        chk("esc_first", first_zone, 0);

        // asynchronous reset in the middle of ALARM
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_siren", siren, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_zones", alarm_zones, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rs = 4'd0;
                1:       rs = 4'd5;
                2:       rs = 4'd9;
                default: rs = 4'($urandom_range(0, 15));
            endcase
            cyc(1'($urandom_range(0, 1)), rs, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 799) == 0));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
